pipe_stage_skid: RTL and testbench

Parametrised, generic pipeline stage register for the CPU pipeline. It replaces the fixed-field inter-stage registers. Each stage has a split data/control payload, a valid/ready handshake, a 2-entry skid buffer so downstream backpressure never creates a combinational ready path upstream, synchronous flush (bubble insertion) and a saturating stall counter. It is instantiated between any two stages (IF/ID … EX2/MEM, MEM/WB).

---
 rtl/cpu_pipe_pkg.sv | 25 ++
 rtl/pipe_sat_counter.sv | 37 +++
 rtl/pipe_stage_skid.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
// Holds the stage state encoding and the control-payload bit positions.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int CTRL_W_DEFAULT = 6;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_BRANCH_NE  = 5;

    // The state encoding equals the number of held entries.
    function automatic logic [1:0] state_occupancy(pipe_state_e st);
        return 2'(st);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Used for pipeline statistics such as stall cycles.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: main entry drives the outputs, a skid entry
// absorbs one extra payload so in_ready is a pure register with no path from out_ready.
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W     = 52,
    parameter int CTRL_W     = CTRL_W_DEFAULT,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    localparam bit CLR_DATA = (CLEAR_DATA != 0);

    pipe_state_e       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_fire;
    logic              out_fire;
    logic              main_valid;

    assign main_valid = (state_q != ST_EMPTY);
    assign in_fire    = in_valid & in_ready_q;
    assign out_fire   = main_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                    state_d     = ST_TWO;
                end else if (out_fire) begin
                    // Clearing ctrl on drain keeps a true bubble on the outputs.
                    main_ctrl_d = '0;
                    if (CLR_DATA) main_data_d = '0;
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_ctrl_d = '0;
                    if (CLR_DATA) skid_data_d = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end

        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // Without CLEAR_DATA the data flops simply hold through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLR_DATA) begin
                main_data_q <= '0;
                skid_data_q <= '0;
            end
        end else begin
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    pipe_sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (main_valid & ~out_ready),
        .clr  (clr_cnt),
        .count(stall_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: table vectors, hand sequences and random traffic
// checked against a 2-deep FIFO model. dut_a: CLEAR_DATA=1/CNT_W=16, dut_b: CLEAR_DATA=0/CNT_W=4.
module tb_pipe_stage_skid;

    localparam int DW = 52;
    localparam int CW = 6;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          clr_cnt;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [CW-1:0] a_out_ctrl;
    logic [1:0]    a_occ;
    logic [15:0]   a_stall;

    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [CW-1:0] b_out_ctrl;
    logic [1:0]    b_occ;
    logic [3:0]    b_stall;

    int checks   = 0;
    int failures = 0;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occ),
        .stall_cnt(a_stall), .clr_cnt(clr_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occ),
        .stall_cnt(b_stall), .clr_cnt(clr_cnt)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: payloads held by the stage, oldest first ({data, ctrl}).
    logic [DW+CW-1:0] exp_q[$];
    int unsigned      m_cnt_a;
    int unsigned      m_cnt_b;

    function automatic logic [CW-1:0] ctrl_of(logic [DW-1:0] d);
        return d[CW-1:0] ^ 6'h15;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        bit can_take, has_out, take, give, stalled;
        can_take = (exp_q.size() < 2);
        has_out  = (exp_q.size() > 0);
        take     = in_valid && can_take;
        give     = has_out && out_ready;
        stalled  = has_out && !out_ready;
        if (rst || clr_cnt) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (stalled) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 15) m_cnt_b++;
        end
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (give) void'(exp_q.pop_front());
            if (take) exp_q.push_back({in_data, in_ctrl});
        end
    endtask

    task automatic model_check();
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        int n;
        n  = exp_q.size();
        ed = (n > 0) ? exp_q[0][DW+CW-1:CW] : '0;
        ec = (n > 0) ? exp_q[0][CW-1:0] : '0;
        chk("a_out_valid", 64'(a_out_valid), 64'(n > 0));
        chk("a_occupancy", 64'(a_occ), 64'(n));
        chk("a_in_ready", 64'(a_in_ready), 64'(n < 2));
        chk("a_out_data", 64'(a_out_data), 64'(ed));
        chk("a_out_ctrl", 64'(a_out_ctrl), 64'(ec));
        chk("a_stall_cnt", 64'(a_stall), 64'(m_cnt_a));
        chk("b_out_valid", 64'(b_out_valid), 64'(n > 0));
        chk("b_occupancy", 64'(b_occ), 64'(n));
        chk("b_out_ctrl", 64'(b_out_ctrl), 64'(ec));
        chk("b_stall_cnt", 64'(b_stall), 64'(m_cnt_b));
        if (n > 0) chk("b_out_data", 64'(b_out_data), 64'(ed));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    task automatic drive(logic r, logic f, logic iv, logic ordy, logic clr, logic [DW-1:0] d);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        clr_cnt   = clr;
        in_data   = d;
        in_ctrl   = ctrl_of(d);
    endtask

    // Table vectors: inputs for one edge and the outputs expected after it.
    typedef struct {
        logic          rst, flush, iv, ordy, clr;
        logic [DW-1:0] data;
        logic          ev;
        logic [DW-1:0] ed;
        logic [1:0]    eocc;
        logic          erdy;
        logic [15:0]   estall;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic f, logic iv, logic ordy, logic clr,
                               logic [DW-1:0] d, logic ev, logic [DW-1:0] ed,
                               logic [1:0] eocc, logic erdy, logic [15:0] es);
        vec_t t;
        t.rst = r; t.flush = f; t.iv = iv; t.ordy = ordy; t.clr = clr; t.data = d;
        t.ev = ev; t.ed = ed; t.eocc = eocc; t.erdy = erdy; t.estall = es;
        return t;
    endfunction

    initial begin
        m_cnt_a = 0;
        m_cnt_b = 0;
        drive(1, 0, 1, 0, 0, 52'hABCD);

        // Reset with a payload offered
        tbl.push_back(v(1, 0, 1, 0, 0, 52'hABCD, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 0, 1, 0, 0, 52'hABCD, 0, 0, 0, 1, 0));
        // Streaming
        for (int k = 1; k <= 10; k++)
            tbl.push_back(v(0, 0, 1, 1, 0, 52'(k), 1, 52'(k), 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        // Backpressure, skid fill and ordered drain
        tbl.push_back(v(0, 0, 1, 0, 0, 52'h1111, 1, 52'h1111, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 52'h2222, 1, 52'h1111, 2, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 52'h3333, 1, 52'h1111, 2, 0, 2));
        tbl.push_back(v(0, 0, 1, 0, 0, 52'h3333, 1, 52'h1111, 2, 0, 3));
        tbl.push_back(v(0, 0, 1, 1, 0, 52'h3333, 1, 52'h2222, 1, 1, 3));
        tbl.push_back(v(0, 0, 1, 1, 0, 52'h3333, 1, 52'h3333, 1, 1, 3));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3));
        // Flush while full with a payload offered; a stalled flush cycle still counts
        tbl.push_back(v(0, 0, 1, 0, 0, 52'h4444, 1, 52'h4444, 1, 1, 3));
        tbl.push_back(v(0, 0, 1, 0, 0, 52'h4545, 1, 52'h4444, 2, 0, 4));
        tbl.push_back(v(0, 1, 1, 0, 0, 52'h5555, 0, 0, 0, 1, 5));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 5));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ordy, tbl[i].clr, tbl[i].data);
            cycle();
            chk("tbl_out_valid", 64'(a_out_valid), 64'(tbl[i].ev));
            chk("tbl_out_data", 64'(a_out_data), 64'(tbl[i].ed));
            chk("tbl_out_ctrl", 64'(a_out_ctrl), 64'(tbl[i].ev ? ctrl_of(tbl[i].ed) : 6'h0));
            chk("tbl_occupancy", 64'(a_occ), 64'(tbl[i].eocc));
            chk("tbl_in_ready", 64'(a_in_ready), 64'(tbl[i].erdy));
            chk("tbl_stall_cnt", 64'(a_stall), 64'(tbl[i].estall));
        end

        // Saturation: dut_b counts to 15 and holds, dut_a keeps counting
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 0, 0, 52'h7777);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i >= 14) chk("sat_hold_b", 64'(b_stall), 64'd15);
        end
        chk("sat_count_a", 64'(a_stall), 64'd20);
        drive(0, 0, 0, 0, 1, 0);
        cycle();
        chk("clr_over_inc_a", 64'(a_stall), 64'd0);
        chk("clr_over_inc_b", 64'(b_stall), 64'd0);

        // Data retention without CLEAR_DATA: flush from TWO, then a drain from ONE
        drive(0, 0, 1, 0, 0, 52'h8888);
        cycle();
        drive(0, 1, 0, 0, 0, 0);
        cycle();
        chk("flush_keep_b_data", 64'(b_out_data), 64'h7777);
        chk("flush_clear_a_data", 64'(a_out_data), 64'h0);
        chk("flush_b_ctrl", 64'(b_out_ctrl), 64'h0);
        drive(0, 0, 1, 1, 0, 52'h9999);
        cycle();
        drive(0, 0, 0, 1, 0, 0);
        cycle();
        chk("drain_keep_b_data", 64'(b_out_data), 64'h9999);
        chk("drain_clear_a_data", 64'(a_out_data), 64'h0);
        chk("drain_b_valid", 64'(b_out_valid), 64'h0);

        // Random traffic against the model
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 32) == 0);
            clr_cnt   = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < (i < 400 ? 6 : 2));
            in_data   = 52'({$urandom, $urandom});
            in_ctrl   = 6'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
